// File: rtl/snake_pkg.sv
// Shared encodings for the snake game logic: directions, game states,
// grid defaults and the reversal helper.
package snake_pkg;

    localparam int COORD_W = 6;
    localparam int GRID_W  = 64;
    localparam int GRID_H  = 48;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // Opposite directions differ only in bit 1 of the encoding.
    localparam logic [1:0] REV_MASK = 2'b10;

    function automatic dir_t rev_dir(input dir_t d);
        return dir_t'(d ^ REV_MASK);
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator. Wrapping uses explicit border compares
// because the grid height is not a power of two.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int X_MAX = GRID_W - 1,
    parameter int Y_MAX = GRID_H - 1,
    parameter int WRAP  = 1
) (
    input  logic [COORD_W-1:0] hx,
    input  logic [COORD_W-1:0] hy,
    input  dir_t               dir,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               oob
);

    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

    // One cell in the requested direction, wrapping or flagging at borders.
    always_comb begin
        nx  = hx;
        ny  = hy;
        oob = 1'b0;
        case (dir)
            DIR_UP: begin
                if (hy == '0) begin
                    if (WRAP != 0) ny = YM;
                    else           oob = 1'b1;
                end else ny = hy - 1'b1;
            end
            DIR_RIGHT: begin
                if (hx == XM) begin
                    if (WRAP != 0) nx = '0;
                    else           oob = 1'b1;
                end else nx = hx + 1'b1;
            end
            DIR_DOWN: begin
                if (hy == YM) begin
                    if (WRAP != 0) ny = '0;
                    else           oob = 1'b1;
                end else ny = hy + 1'b1;
            end
            default: begin
                if (hx == '0) begin
                    if (WRAP != 0) nx = XM;
                    else           oob = 1'b1;
                end else nx = hx - 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game sequencer: owns the four segment positions, the direction latch,
// score and the IDLE/RUN/PAUSE/DEAD state machine.
// Optional build macro SNAKE_DIR_QUEUE_EN replaces the single pending
// direction register with a 2-entry request FIFO.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int X_MAX   = GRID_W - 1,
    parameter int Y_MAX   = GRID_H - 1,
    parameter int START_X = 32,
    parameter int START_Y = 24,
    parameter int WRAP    = 1,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               pause_tgl,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic [5:0]         food_x,
    input  logic [5:0]         food_y,
    output logic [5:0]         Px1,
    output logic [5:0]         Px2,
    output logic [5:0]         Px3,
    output logic [5:0]         Px4,
    output logic [5:0]         Py1,
    output logic [5:0]         Py2,
    output logic [5:0]         Py3,
    output logic [5:0]         Py4,
    output logic               ate,
    output logic               dead,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);

    logic [3:0][COORD_W-1:0] sx, sy;
    state_t st;
    dir_t   cdir, nxt_cdir, mv_dir;
    logic   step, accept, oob, hit_body, kill, eat;
    logic [COORD_W-1:0] nx, ny;

    assign {Px1, Px2, Px3, Px4} = {sx[0], sx[1], sx[2], sx[3]};
    assign {Py1, Py2, Py3, Py4} = {sy[0], sy[1], sy[2], sy[3]};
    assign state = st;
    assign step  = (st == ST_RUN) && tick;

    snake_next_head #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .WRAP(WRAP)) u_next (
        .hx(sx[0]), .hy(sy[0]), .dir(mv_dir), .nx(nx), .ny(ny), .oob(oob)
    );

    // Step outcome: the head may only bite seg2/seg3 of the old body.
    always_comb begin
        hit_body = ((nx == sx[1]) && (ny == sy[1])) || ((nx == sx[2]) && (ny == sy[2]));
        kill     = oob || hit_body;
        eat      = (nx == food_x) && (ny == food_y);
    end

`ifdef SNAKE_DIR_QUEUE_EN
    dir_t       q0, q1, a0, a1, last_dir, nxt_q0, nxt_q1;
    logic [1:0] qn, an, nxt_qn;
    logic       pop;

    // FIFO pop on a step, then reversal-checked push against the newest entry.
    always_comb begin
        pop      = step && (qn != 2'd0);
        nxt_cdir = pop ? q0 : cdir;
        a0       = pop ? q1 : q0;
        a1       = q1;
        an       = pop ? qn - 2'd1 : qn;
        mv_dir   = nxt_cdir;
        last_dir = (an == 2'd0) ? nxt_cdir : ((an == 2'd1) ? a0 : a1);
        accept   = dir_valid && (st != ST_DEAD) && (dir_t'(dir_req) != rev_dir(last_dir));
        nxt_q0   = a0;
        nxt_q1   = a1;
        nxt_qn   = an;
        if (accept) begin
            case (an)
                2'd0:    begin nxt_q0 = dir_t'(dir_req); nxt_qn = 2'd1; end
                2'd1:    begin nxt_q1 = dir_t'(dir_req); nxt_qn = 2'd2; end
                default: nxt_q1 = dir_t'(dir_req);
            endcase
        end
    end
`else
    dir_t pend, nxt_pend;

    // The step consumes the old pending value; a same-edge request is checked
    // against the direction being committed on that edge.
    always_comb begin
        mv_dir   = pend;
        nxt_cdir = step ? pend : cdir;
        accept   = dir_valid && (st != ST_DEAD) && (dir_t'(dir_req) != rev_dir(nxt_cdir));
        nxt_pend = accept ? dir_t'(dir_req) : pend;
    end
`endif

    // Game FSM, segment shift register, direction state and score.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sx[i] <= COORD_W'(START_X - i);
                sy[i] <= COORD_W'(START_Y);
            end
            cdir  <= DIR_RIGHT;
`ifdef SNAKE_DIR_QUEUE_EN
            qn    <= 2'd0;
            q0    <= DIR_RIGHT;
            q1    <= DIR_RIGHT;
`else
            pend  <= DIR_RIGHT;
`endif
            st    <= ST_IDLE;
            score <= '0;
            ate   <= 1'b0;
            dead  <= 1'b0;
        end else begin
            ate  <= 1'b0;
            cdir <= nxt_cdir;
`ifdef SNAKE_DIR_QUEUE_EN
            q0   <= nxt_q0;
            q1   <= nxt_q1;
            qn   <= nxt_qn;
`else
            pend <= nxt_pend;
`endif
            case (st)
                ST_IDLE: if (start) st <= ST_RUN;
                ST_RUN: begin
                    if (tick && kill) begin
                        st   <= ST_DEAD;
                        dead <= 1'b1;
                    end else begin
                        if (tick) begin
                            sx    <= {sx[2:0], nx};
                            sy    <= {sy[2:0], ny};
                            if (eat) begin
                                ate <= 1'b1;
                                if (score != '1) score <= score + 1'b1;
                            end
                        end
                        if (pause_tgl) st <= ST_PAUSE;
                    end
                end
                ST_PAUSE: if (pause_tgl) st <= ST_RUN;
                default: begin
`ifdef SNAKE_DIR_QUEUE_EN
                    qn <= 2'd0;
`endif
                    if (start) begin
                        for (int i = 0; i < 4; i++) begin
                            sx[i] <= COORD_W'(START_X - i);
                            sy[i] <= COORD_W'(START_Y);
                        end
                        cdir  <= DIR_RIGHT;
`ifndef SNAKE_DIR_QUEUE_EN
                        pend  <= DIR_RIGHT;
`endif
                        score <= '0;
                        dead  <= 1'b0;
                        st    <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl: a wrapping instance (8-bit score) and
// a border-killing instance (2-bit score) share all inputs; a grid-level model
// predicts each instance's outputs after every clock edge.
module tb_snake_move_ctrl;

    logic clk = 1'b0;
    logic rst, tick, start, pause_tgl, dir_valid;
    logic [1:0] dir_req;
    logic [5:0] food_x, food_y;

    logic [5:0] ax1, ax2, ax3, ax4, ay1, ay2, ay3, ay4;
    logic       a_ate, a_dead;
    logic [7:0] a_score;
    logic [1:0] a_state;
    logic [5:0] bx1, bx2, bx3, bx4, by1, by2, by3, by4;
    logic       b_ate, b_dead;
    logic [1:0] b_score;
    logic [1:0] b_state;

    snake_move_ctrl #(.WRAP(1), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause_tgl(pause_tgl),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .Px1(ax1), .Px2(ax2), .Px3(ax3), .Px4(ax4), .Py1(ay1), .Py2(ay2), .Py3(ay3), .Py4(ay4),
        .ate(a_ate), .dead(a_dead), .score(a_score), .state(a_state)
    );

    snake_move_ctrl #(.WRAP(0), .SCORE_W(2)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause_tgl(pause_tgl),
        .dir_valid(dir_valid), .dir_req(dir_req), .food_x(food_x), .food_y(food_y),
        .Px1(bx1), .Px2(bx2), .Px3(bx3), .Px4(bx4), .Py1(by1), .Py2(by2), .Py3(by3), .Py4(by4),
        .ate(b_ate), .dead(b_dead), .score(b_score), .state(b_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px[4];
        int py[4];
        int cdir;
        int pend;
        int q[2];
        int qn;
        int st;    // 0 idle, 1 run, 2 pause, 3 dead
        bit ate;
        int score;
    } mdl_t;

    mdl_t m1, m0;
    logic [59:0] q1[$], q0[$];
    int ntest = 0, nfail = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        for (int i = 0; i < 4; i++) begin
            m.px[i] = 32 - i;
            m.py[i] = 24;
        end
        m.cdir = 1; m.pend = 1; m.q[0] = 1; m.q[1] = 1; m.qn = 0;
        m.st = 0; m.ate = 0; m.score = 0;
        return m;
    endfunction

    // One clock edge of the game rules, stated on plain integer coordinates.
    function automatic mdl_t mstep(mdl_t m, bit wrap, int smax, bit r, bit s, bit p,
                                   bit t, bit v, int d, int fx, int fy);
        mdl_t n;
        int mv, hx, hy, last;
        bit died;
        n = m;
        n.ate = 0;
        died = 0;
        if (r) return mreset();
        if (m.st == 3) begin
            n.qn = 0;
            if (s) begin
                n = mreset();
                n.st = 1;
            end
            return n;
        end
        if (m.st == 1 && t) begin
`ifdef SNAKE_DIR_QUEUE_EN
            if (n.qn > 0) begin
                n.cdir = n.q[0];
                n.q[0] = n.q[1];
                n.qn--;
            end
            mv = n.cdir;
`else
            n.cdir = m.pend;
            mv = m.pend;
`endif
            hx = m.px[0] + ((mv == 1) ? 1 : (mv == 3) ? -1 : 0);
            hy = m.py[0] + ((mv == 2) ? 1 : (mv == 0) ? -1 : 0);
            if (hx > 63) begin if (wrap) hx = 0;  else died = 1; end
            if (hx < 0)  begin if (wrap) hx = 63; else died = 1; end
            if (hy > 47) begin if (wrap) hy = 0;  else died = 1; end
            if (hy < 0)  begin if (wrap) hy = 47; else died = 1; end
            if ((hx == m.px[1] && hy == m.py[1]) || (hx == m.px[2] && hy == m.py[2])) died = 1;
            if (!died) begin
                for (int i = 3; i > 0; i--) begin
                    n.px[i] = m.px[i-1];
                    n.py[i] = m.py[i-1];
                end
                n.px[0] = hx;
                n.py[0] = hy;
                if (hx == fx && hy == fy) begin
                    n.ate = 1;
                    if (n.score < smax) n.score++;
                end
            end
        end
        if (v) begin
`ifdef SNAKE_DIR_QUEUE_EN
            last = (n.qn == 0) ? n.cdir : n.q[n.qn-1];
            if (d != (last ^ 2)) begin
                if (n.qn < 2) begin
                    n.q[n.qn] = d;
                    n.qn++;
                end else n.q[1] = d;
            end
`else
            last = n.cdir;
            if (d != (last ^ 2)) n.pend = d;
`endif
        end
        case (m.st)
            0: if (s) n.st = 1;
            1: if (died) n.st = 3; else if (p) n.st = 2;
            default: if (p) n.st = 1;
        endcase
        return n;
    endfunction

    function automatic logic [59:0] pk(mdl_t m);
        return {6'(m.px[0]), 6'(m.px[1]), 6'(m.px[2]), 6'(m.px[3]),
                6'(m.py[0]), 6'(m.py[1]), 6'(m.py[2]), 6'(m.py[3]),
                m.ate, (m.st == 3), 8'(m.score), 2'(m.st)};
    endfunction

    wire [59:0] act1 = {ax1, ax2, ax3, ax4, ay1, ay2, ay3, ay4, a_ate, a_dead, a_score, a_state};
    wire [59:0] act0 = {bx1, bx2, bx3, bx4, by1, by2, by3, by4, b_ate, b_dead, 6'd0, b_score, b_state};

    // Monitor: every edge produces one output snapshot per instance.
    always @(posedge clk) begin
        logic [59:0] e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            ntest++;
            if (act1 !== e) begin
                nfail++;
                $display("FAIL wrap_inst got %h expected %h at %0t", act1, e, $time);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            ntest++;
            if (act0 !== e) begin
                nfail++;
                $display("FAIL border_inst got %h expected %h at %0t", act0, e, $time);
            end
        end
    end

    // Drive one cycle of inputs, predict the result, then clock it.
    task automatic cyc(bit r = 0, bit s = 0, bit p = 0, bit t = 0, bit v = 0, int d = 0);
        rst = r; start = s; pause_tgl = p; tick = t; dir_valid = v; dir_req = 2'(d);
        m1 = mstep(m1, 1, 255, r, s, p, t, v, d, int'(food_x), int'(food_y));
        m0 = mstep(m0, 0, 3,   r, s, p, t, v, d, int'(food_x), int'(food_y));
        q1.push_back(pk(m1));
        q0.push_back(pk(m0));
        @(posedge clk);
        #2;
        rst = 0; start = 0; pause_tgl = 0; tick = 0; dir_valid = 0;
    endtask

    task automatic chk(string nm, int act, int exp);
        ntest++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int hx, hy, dd;
        rst = 1; start = 0; pause_tgl = 0; tick = 0; dir_valid = 0; dir_req = 0;
        food_x = 10; food_y = 10;
        m1 = mreset(); m0 = mreset();

        cyc(1);
        chk("reset_state", a_state, 0);
        chk("reset_px1", ax1, 32);
        chk("reset_px4", ax4, 29);
        cyc(0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk("run3_px1", ax1, 35);
        chk("run3_px4", ax4, 32);
        chk("run3_py1", ay1, 24);
        chk("run3_state", a_state, 1);

        // food directly ahead of the start head
        cyc(1);
        food_x = 33; food_y = 24;
        cyc(0, 1);
        cyc(0, 0, 0, 1);
        chk("food_ate", a_ate, 1);
        chk("food_score", a_score, 1);
        cyc();
        chk("food_ate_clear", a_ate, 0);
        cyc(0, 0, 0, 1);
        chk("food_score_hold", a_score, 1);
        food_x = 10; food_y = 10;

        // right border: wrap instance wraps, border instance dies
        cyc(1);
        cyc(0, 1);
        repeat (31) cyc(0, 0, 0, 1);
        chk("edge_px1", ax1, 63);
        cyc(0, 0, 0, 1);
        chk("wrap_px1", ax1, 0);
        chk("wrap_px2", ax2, 63);
        chk("kill_state", b_state, 3);
        chk("kill_dead", b_dead, 1);
        chk("kill_px1", bx1, 63);
        cyc(0, 1);
        chk("restart_px1", bx1, 32);
        chk("restart_state", b_state, 1);
        chk("restart_score", b_score, 0);
        chk("start_ignored", a_state, 1);

        // top border wrap
        cyc(0, 0, 0, 0, 1, 0);
        repeat (24) cyc(0, 0, 0, 1);
        chk("top_py1", ay1, 0);
        cyc(0, 0, 0, 1);
        chk("wrap_py1", ay1, 47);

        // reversal rejected, perpendicular accepted
        cyc(1);
        cyc(0, 1);
        cyc(0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 1);
        chk("rev_px1", ax1, 33);
        cyc(0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 1);
        chk("turn_py1", ay1, 25);

        // pause holds, resume steps, reset mid-game
        cyc(0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);
        chk("pause_py1", ay1, 25);
        chk("pause_state", a_state, 2);
        cyc(0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("resume_py1", ay1, 26);
        cyc(1);
        chk("midrst_px1", ax1, 32);
        chk("midrst_state", a_state, 0);

        // simultaneous pause and tick: step, then pause
        cyc(0, 1);
        cyc(0, 0, 1, 1);
        chk("pt_px1", ax1, 33);
        chk("pt_state", a_state, 2);

        // score saturation on the 2-bit instance
        cyc(1);
        cyc(0, 1);
        for (int i = 0; i < 5; i++) begin
            food_x = 6'(33 + i); food_y = 24;
            cyc(0, 0, 0, 1);
        end
        chk("sat_score_wide", a_score, 5);
        chk("sat_score_narrow", b_score, 3);

        // randomized play, food often placed next to the wrap-instance head
        for (int k = 0; k < 3000; k++) begin
            dd = $urandom_range(3);
            if ($urandom_range(2) == 0) begin
                hx = (m1.px[0] + ((dd == 1) ? 1 : (dd == 3) ? 63 : 0)) % 64;
                hy = (m1.py[0] + ((dd == 2) ? 1 : (dd == 0) ? 47 : 0)) % 48;
                food_x = 6'(hx); food_y = 6'(hy);
            end else begin
                food_x = 6'($urandom_range(63)); food_y = 6'($urandom_range(47));
            end
            cyc($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(29) == 0,
                $urandom_range(1) == 0, $urandom_range(2) == 0, int'($urandom_range(3)));
        end

        #5;
        ntest++;
        if (q1.size() != 0 || q0.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain got %0d/%0d left expected 0", q1.size(), q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
